// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit feeding the decoder.
//   Holds the PC and issues one word read at a time to instruction memory
//   over a valid/ready request channel. Each response is captured into a
//   1-entry output register that is presented to decode with valid/ready.
//   A redirect reloads the PC, flushes the output register and discards
//   any response still in flight. A misaligned redirect target halts fetch
//   until reset.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready/addr       request channel (addr = pc)
//   imem_rsp_valid/data             response, one-cycle pulse
//   redirect_valid/pc               load new PC
//   inst_valid/ready, inst, inst_addr  output to decode
//   fetch_fault                     sticky misaligned-redirect flag
//
// State | meaning
//   IDLE | one-cycle wait after reset before the first request
//   REQ  | request pc, waiting for the output register to drain and ready
//   WAIT | one request outstanding; kill_q marks its response as stale
//   HALT | misaligned redirect seen; fetch stopped until reset
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic        req_fire;

  // A request may only go out when the output register will be free by the
  // time the response returns, so a response never finds it occupied.
  assign imem_req_valid = (state_q == S_REQ) && (!inst_valid_q || inst_ready) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_addr   = inst_addr_q;
  assign fetch_fault = fetch_fault_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    inst_valid_d  = inst_valid_q;
    inst_d        = inst_q;
    inst_addr_d   = inst_addr_q;
    fetch_fault_d = fetch_fault_q;

    if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            inst_d       = imem_rsp_data;
            inst_addr_d  = pc_q - 32'd4;
            inst_valid_d = 1'b1;
          end
          state_d = S_REQ;
        end
      end
      default: ;
    endcase

    // Redirect overrides everything above, including a response landing in
    // the same cycle: that response belongs to the old path and is dropped.
    if (redirect_valid && (state_q != S_HALT)) begin
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_addr_d  = inst_addr_q;
      if (redirect_pc[1:0] != 2'b00) begin
        fetch_fault_d = 1'b1;
        kill_d        = 1'b0;
        pc_d          = pc_q;
        state_d       = S_HALT;
      end else begin
        pc_d = redirect_pc;
        if ((state_q == S_WAIT) && !imem_rsp_valid) begin
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          kill_d  = 1'b0;
          state_d = S_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_q        <= 32'd0;
      inst_addr_q   <= 32'd0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      inst_valid_q  <= inst_valid_d;
      inst_q        <= inst_d;
      inst_addr_q   <= inst_addr_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

endmodule
